// File: rtl/axi_ar_slice_if.sv
// rtl/axi_ar_slice_if.sv - AXI read-address channel bundle
// Purpose: one AR channel between a request source (master modport) and a sink
//          (slave modport). The splitter uses one instance on each side.
// Ports:
//   arvalid / arready     handshake (master drives arvalid, slave drives arready)
//   arid, araddr, arlen   request ID, start address, beats-1
//   arsize, arbrust       beat size, burst type (0 FIXED, 1 INCR, 2 WRAP)
//   arlock, arcache, arprot, arqos, arregion   sideband, passed through
//   arsplit_last          final sub-request marker (master modport only)
interface axi_ar_slice_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 8
);
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [LEN_WIDTH-1:0]  arlen;
   logic [2:0]            arsize;
   logic [1:0]            arbrust;
   logic [1:0]            arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic [3:0]            arqos;
   logic [3:0]            arregion;
   logic                  arsplit_last;

   modport master (
      output arvalid, arid, araddr, arlen, arsize, arbrust,
             arlock, arcache, arprot, arqos, arregion, arsplit_last,
      input  arready
   );

   modport slave (
      input  arvalid, arid, araddr, arlen, arsize, arbrust,
             arlock, arcache, arprot, arqos, arregion,
      output arready
   );
endinterface

// File: rtl/axi_ar_slice.sv
// rtl/axi_ar_slice.sv - AXI AR slice: request FIFO plus 16-beat burst splitter
// Purpose: queues accepted read-address requests and issues each one on the
//          master side, cutting long INCR/FIXED bursts into 16-beat pieces.
// Ports:
//   clk, rst_n    single clock, asynchronous active-low reset
//   s             slave-side AR channel (requests in, S_LEN_WIDTH arlen)
//   m             master-side AR channel (sub-requests out, M_LEN_W arlen,
//                 arsplit_last high on the final piece of a request)
//   fifo_level    number of requests currently held, including the one
//                 being issued
module axi_ar_slice #(
   parameter int ADDR_WIDTH   = 32,
   parameter int ID_MAX_WIDTH = 4,
   parameter int DEPTH        = 4,
   parameter int S_LEN_WIDTH  = 8,
   parameter int SPLIT_EN     = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   axi_ar_slice_if.slave            s,
   axi_ar_slice_if.master           m,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int M_LEN_W = (SPLIT_EN != 0) ? 4 : S_LEN_WIDTH;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   typedef struct packed {
      logic [ID_MAX_WIDTH-1:0] id;
      logic [ADDR_WIDTH-1:0]   addr;
      logic [S_LEN_WIDTH-1:0]  len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic [1:0]              lock;
      logic [3:0]              cache;
      logic [2:0]              prot;
      logic [3:0]              qos;
      logic [3:0]              region;
   } req_t;

   typedef enum logic {IDLE, SPLIT} state_t;

   req_t                   mem [DEPTH];
   req_t                   s_req;
   req_t                   head;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;
   logic [PTR_W:0]         count_nxt;
   logic                   s_ready_q;
   logic                   m_valid_q;
   state_t                 state;
   logic [ADDR_WIDTH-1:0]  cur_addr;
   logic [S_LEN_WIDTH-1:0] rem;
   logic                   push;
   logic                   issue;
   logic                   pop;
   logic                   need_split;
   logic                   last;
   logic [ADDR_WIDTH-1:0]  step;
   logic [ADDR_WIDTH-1:0]  base;
   logic [ADDR_WIDTH-1:0]  nxt_addr;

   always_comb begin
      s_req.id     = s.arid;
      s_req.addr   = s.araddr;
      s_req.len    = s.arlen;
      s_req.size   = s.arsize;
      s_req.burst  = s.arbrust;
      s_req.lock   = s.arlock;
      s_req.cache  = s.arcache;
      s_req.prot   = s.arprot;
      s_req.qos    = s.arqos;
      s_req.region = s.arregion;
   end

   assign head = mem[rd_ptr];

   // WRAP bursts longer than 16 beats are illegal and go out once, truncated.
   assign need_split = (SPLIT_EN != 0) && (head.len > S_LEN_WIDTH'(15)) &&
                       (head.burst != BURST_WRAP);

   // In SPLIT, rem counts the pieces still to issue including the current one.
   assign last = (state == IDLE) ? !need_split : (rem == S_LEN_WIDTH'(1));

   assign push  = s.arvalid && s_ready_q;
   assign issue = m_valid_q && m.arready;
   assign pop   = issue && last;

   assign step     = ADDR_WIDTH'(16) << head.size;
   assign base     = (state == IDLE) ? head.addr : cur_addr;
   assign nxt_addr = (head.burst == BURST_FIXED) ? base : base + step;

   always_comb begin
      count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_req;
      end
   end

   // Ready and valid are registered from the next occupancy, so s_arready
   // never sees m_arready combinationally and a new head needs no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count     <= count_nxt;
         s_ready_q <= count_nxt < (PTR_W+1)'(DEPTH);
         m_valid_q <= count_nxt != '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_addr <= '0;
         rem      <= '0;
      end else if (issue) begin
         if (last) begin
            state <= IDLE;
         end else begin
            state    <= SPLIT;
            cur_addr <= nxt_addr;
            rem      <= (state == IDLE) ? (head.len >> 4) : rem - S_LEN_WIDTH'(1);
         end
      end
   end

   assign s.arready  = s_ready_q;
   assign m.arvalid  = m_valid_q;
   assign fifo_level = count;

   // Fields are forced to zero while nothing is queued so the unreset
   // storage never shows on the bus.
   always_comb begin
      m.arid           = '0;
      m.araddr         = '0;
      m.arlen          = '0;
      m.arsize         = '0;
      m.arbrust        = '0;
      m.arlock         = '0;
      m.arcache        = '0;
      m.arprot         = '0;
      m.arqos          = '0;
      m.arregion       = '0;
      m.arsplit_last   = 1'b0;
      if (m_valid_q) begin
         m.arid         = head.id;
         m.araddr       = base;
         m.arlen        = last ? M_LEN_W'(head.len) : M_LEN_W'(15);
         m.arsize       = head.size;
         m.arbrust      = head.burst;
         m.arlock       = head.lock;
         m.arcache      = head.cache;
         m.arprot       = head.prot;
         m.arqos        = head.qos;
         m.arregion     = head.region;
         m.arsplit_last = last;
      end
   end
endmodule

// File: tb/tb_axi_ar_slice.sv
// tb/tb_axi_ar_slice.sv - self-checking bench for axi_ar_slice
module tb_axi_ar_slice;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;
   int model_level = 0;
   int since_rst = 0;
   int ready_mode = 0;
   int n_issue = 0;
   logic [63:0] exp_q[$];
   logic [63:0] snap;
   logic [63:0] prev_snap;
   logic [63:0] e;
   logic        prev_stall = 1'b0;

   axi_ar_slice_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8)) s_if ();
   axi_ar_slice_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)) m_if ();

   axi_ar_slice #(
      .ADDR_WIDTH(32), .ID_MAX_WIDTH(4), .DEPTH(DEPTH), .S_LEN_WIDTH(8), .SPLIT_EN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(
      input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
      input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock,
      input logic [3:0] cache, input logic [2:0] prot, input logic [3:0] qos,
      input logic [3:0] region, input logic last);
      return {1'b0, id, addr, len, size, burst, lock, cache, prot, qos, region, last};
   endfunction

   // Reference: a request becomes floor(len/16)+1 pieces of 16 beats (last one
   // len%16), addresses stepping by 16 beats of 2^size bytes, unless it is
   // short, WRAP, or FIXED (which repeats its address).
   task automatic model_accept();
      int unsigned len   = s_if.arlen;
      int unsigned n     = len / 16 + 1;
      logic [31:0] stepv = 32'd16 << s_if.arsize;
      logic [31:0] a;
      if (len <= 15 || s_if.arbrust == 2'd2) begin
         exp_q.push_back(pack(s_if.arid, s_if.araddr, 4'(len % 16), s_if.arsize, s_if.arbrust,
                              s_if.arlock, s_if.arcache, s_if.arprot, s_if.arqos,
                              s_if.arregion, 1'b1));
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            a = (s_if.arbrust == 2'd0) ? s_if.araddr : s_if.araddr + 32'(i) * stepv;
            exp_q.push_back(pack(s_if.arid, a, (i == int'(n) - 1) ? 4'(len % 16) : 4'd15,
                                 s_if.arsize, s_if.arbrust, s_if.arlock, s_if.arcache,
                                 s_if.arprot, s_if.arqos, s_if.arregion, i == int'(n) - 1));
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) since_rst = 0;
      else        since_rst++;
   end

   // Monitor at the falling edge: predicts the handshakes of the next rising edge.
   always @(negedge clk) begin
      snap = pack(m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arbrust, m_if.arlock,
                  m_if.arcache, m_if.arprot, m_if.arqos, m_if.arregion, m_if.arsplit_last);
      if (!rst_n) begin
         check("rst_arvalid", m_if.arvalid, 0);
         check("rst_arready", s_if.arready, 0);
         check("rst_level", fifo_level, 0);
         check("rst_fields", snap, 0);
         exp_q.delete();
         model_level = 0;
         prev_stall = 1'b0;
      end else begin
         check("level", fifo_level, model_level);
         check("arvalid", m_if.arvalid, model_level != 0);
         if (since_rst > 0) check("arready", s_if.arready, model_level < DEPTH);
         if (prev_stall) check("stable", snap, prev_snap);
         if (m_if.arvalid && m_if.arready) begin
            n_issue++;
            if (exp_q.size() == 0) begin
               check("unexpected_issue", snap, 0);
            end else begin
               e = exp_q.pop_front();
               check("subreq", snap, e);
               if (e[0]) model_level--;
            end
         end
         if (s_if.arvalid && s_if.arready) begin
            model_accept();
            model_level++;
         end
         prev_stall = m_if.arvalid && !m_if.arready;
         prev_snap  = snap;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_if.arready = 1'b0;
            1:       m_if.arready = 1'b1;
            default: m_if.arready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      s_if.arvalid  = 1'b1;
      s_if.arid     = id;
      s_if.araddr   = addr;
      s_if.arlen    = len;
      s_if.arsize   = size;
      s_if.arbrust  = burst;
      s_if.arlock   = 2'($urandom_range(0, 3));
      s_if.arcache  = 4'($urandom_range(0, 15));
      s_if.arprot   = 3'($urandom_range(0, 7));
      s_if.arqos    = 4'($urandom_range(0, 15));
      s_if.arregion = 4'($urandom_range(0, 15));
      @(negedge clk);
      while (!s_if.arready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!s_if.arready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_if.arvalid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while ((model_level != 0 || exp_q.size() != 0) && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check(tag, (model_level == 0) && (exp_q.size() == 0), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      s_if.arvalid = 1'b0;
      s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
      s_if.arbrust = '0; s_if.arlock = '0; s_if.arcache = '0; s_if.arprot = '0;
      s_if.arqos = '0; s_if.arregion = '0; s_if.arsplit_last = 1'b0;
      m_if.arready = 1'b0;

      #3;
      check("init_arready", s_if.arready, 0);
      check("init_arvalid", m_if.arvalid, 0);
      check("init_level", fifo_level, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_arready", s_if.arready, 1);

      ready_mode = 1;
      @(posedge clk);
      #1;
      send(4'h1, 32'h0000_1000, 8'd3, 3'd2, 2'd1);
      wait_idle("drain_short");
      send(4'h2, 32'h0000_2000, 8'd39, 3'd2, 2'd1);
      wait_idle("drain_incr39");
      send(4'h3, 32'h0000_3000, 8'd31, 3'd2, 2'd0);
      wait_idle("drain_fixed31");
      send(4'h4, 32'h0000_5000, 8'd40, 3'd1, 2'd2);
      wait_idle("drain_wrap40");
      send(4'h6, 32'hFFFF_FF80, 8'd255, 3'd3, 2'd1);
      wait_idle("drain_wrapround");

      ready_mode = 0;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(4'(i + 8), 32'h0001_0000 + 32'(i) * 32'h100, 8'(i * 9), 3'd2, 2'd1);
         end
         begin
            repeat (20) @(posedge clk);
            #1;
            check("full_level", fifo_level, 4);
            check("full_arready", s_if.arready, 0);
            ready_mode = 1;
         end
      join
      wait_idle("drain_full");

      ready_mode = 2;
      for (int i = 0; i < 60; i++) begin
         send(4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_F000 | 32'($urandom_range(0, 4095)) : $urandom,
              ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      wait_idle("drain_random");

      ready_mode = 1;
      send(4'h5, 32'h0000_4000, 8'd63, 3'd2, 2'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_arvalid", m_if.arvalid, 0);
      check("midrst_level", fifo_level, 0);
      check("midrst_arready", s_if.arready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n0 = n_issue;
      @(posedge clk);
      #1;
      check("postrst_arready", s_if.arready, 1);
      repeat (30) @(posedge clk);
      #1;
      check("postrst_no_issue", n_issue, n0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_ar_slice.md
AXI_AR_SLICE -- requirements
Module: axi_ar_slice

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-002 Parameter ID_MAX_WIDTH, default 4, ID width on both sides.
REQ-003 Parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-004 Parameter S_LEN_WIDTH, default 8, slave-side arlen width (8 = AXI4 bursts up to 256 beats).
REQ-005 Parameter SPLIT_EN, default 1; M_LEN_W = 4 when 1, S_LEN_WIDTH when 0.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 s_arvalid / s_arready  in / out  1 / 1  slave-side AR handshake.
REQ-009 s_arid, s_araddr, s_arlen  in  ID_MAX_WIDTH, ADDR_WIDTH, S_LEN_WIDTH  request ID, start address, beats-1.
REQ-010 s_arsize, s_arbrust  in  3, 2  beat size, burst type (0 FIXED, 1 INCR, 2 WRAP).
REQ-011 s_arlock, s_arcache, s_arprot, s_arqos, s_arregion  in  2, 4, 3, 4, 4  sideband, carried unchanged.
REQ-012 m_arvalid / m_arready  out / in  1 / 1  master-side AR handshake.
REQ-013 m_arid, m_araddr, m_arlen  out  ID_MAX_WIDTH, ADDR_WIDTH, M_LEN_W  issued sub-request fields.
REQ-014 m_arsize, m_arbrust, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion  out  3, 2, 2, 4, 3, 4, 4  copies of the accepted request.
REQ-015 m_arsplit_last  out  1  high on the final (or only) sub-request of a request.
REQ-016 fifo_level  out  $clog2(DEPTH)+1  number of FIFO entries held.

Function
REQ-017 A request is accepted when s_arvalid && s_arready; a sub-request is issued when m_arvalid && m_arready.
REQ-018 s_arready SHALL be a register output, high when fifo_level < DEPTH, with no combinational path from m_arready.
REQ-019 Accepted requests SHALL be written into a DEPTH-entry FIFO in order; one write and one read in the same cycle leave fifo_level unchanged, including when full.
REQ-020 Minimum latency from acceptance at edge N to m_arvalid high is one cycle (after edge N); sustained throughput is one sub-request per cycle.
REQ-021 m_* outputs SHALL be held stable while m_arvalid && !m_arready, and m_arvalid SHALL NOT drop before the handshake.
REQ-022 The splitter FSM SHALL have two states: IDLE (issuing the first sub-request of the FIFO head, or empty) and SPLIT (issuing the continuation sub-requests).
REQ-023 If SPLIT_EN=0 or s_arlen <= 15, the request SHALL be issued once, unchanged, with m_arsplit_last=1; the FSM stays in IDLE.
REQ-024 If SPLIT_EN=1 and arlen > 15, the block SHALL issue floor(arlen/16)+1 sub-requests: all but the last with m_arlen=15, the last with m_arlen=arlen[3:0].
REQ-025 The first sub-request goes IDLE->SPLIT on handshake; SPLIT->IDLE on the handshake of the sub-request with m_arsplit_last=1, and the FIFO head is then popped.
REQ-026 Sub-request address: INCR adds (16 << arsize) per sub-request, modulo 2^ADDR_WIDTH; FIXED repeats the original address.
REQ-027 WRAP with arlen > 15 is illegal input; the block SHALL issue it once with m_arlen=arlen[3:0] and m_arsplit_last=1.
REQ-028 All sub-requests SHALL carry the original ID and sideband unchanged.
REQ-029 The next FIFO entry SHALL be issued in the cycle after the last sub-request handshake of the previous one, with no idle bubble.

Reset
REQ-030 While rst_n=0: s_arready=0, m_arvalid=0, m_arsplit_last=0, fifo_level=0, FSM=IDLE; all other m_* outputs are 0.
REQ-031 s_arready SHALL rise in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-split SHALL discard all queued and partially issued requests.

Verification
REQ-033 arlen=3, araddr=0x1000, INCR -> one issue with m_arlen=3, addr 0x1000, split_last=1, one cycle after acceptance.
REQ-034 arlen=39, arsize=2, addr 0x2000, INCR -> three issues: (0x2000,15), (0x2040,15), (0x2080,7); split_last only on the third.
REQ-035 arlen=31, FIXED, addr 0x3000 -> two issues, both at 0x3000 with m_arlen=15.
REQ-036 m_arready=0, 5 back-to-back requests, DEPTH=4 -> fifo_level reaches 4, s_arready=0, outputs stable; m_arready=1 -> all drained in order.
REQ-037 arlen=255, arsize=3, addr 0xFFFFFF80 -> 16 issues, 2nd at 0x00000000 (wrap-around), last m_arlen=15.
REQ-038 rst_n pulsed low during the second sub-request -> m_arvalid=0 immediately, fifo_level=0, nothing issued afterward.
